// File: rtl/b06_multi_pkg.sv
// Shared types for the b06 multi-channel handshake controller: FSM state enum
// and the USCITE phase codes.
package b06_multi_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT,
        ST_ENIN,
        ST_ENIN_W,
        ST_INTR,
        ST_INTR_1,
        ST_INTR_W
    } state_t;

    localparam logic [1:0] USC_IDLE = 2'd0;
    localparam logic [1:0] USC_EN   = 2'd1;
    localparam logic [1:0] USC_INT  = 2'd2;
    localparam logic [1:0] USC_INT1 = 2'd3;

endpackage

// File: rtl/b06_rr_arb.sv
// Round-robin search: picks the first set request bit starting one position
// after the previously served channel, wrapping modulo N_CH.
module b06_rr_arb #(
    parameter  int N_CH = 4,
    localparam int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    always_comb begin : search
        int cand;
        cand    = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = (int'(last) + i) % N_CH;
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/b06_multi_ctrl.sv
// Multi-channel request/acknowledge controller with round-robin grant.
// Optional ENIN_W timeout is enabled by defining B06_MULTI_TOUT_EN.
module b06_multi_ctrl
    import b06_multi_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int TOUT_W = 8,
    localparam int IW     = $clog2(N_CH)
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [N_CH-1:0]   EQL,
    input  logic              CONT_EQL,
    input  logic [TOUT_W-1:0] TOUT_LIM,
    output logic              ACKOUT,
    output logic [IW-1:0]     CC_MUX,
    output logic              CC_VALID,
    output logic [1:0]        USCITE,
    output logic              ENABLE_COUNT,
    output logic              TIMEOUT
);

    state_t        state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] gntIdx;
    logic          gntAny;
    logic          reqG;
    logic          toutCond;
    logic          toutExit;

    b06_rr_arb #(.N_CH(N_CH)) u_arb (
        .req     (EQL),
        .last    (last_q),
        .gnt_idx (gntIdx),
        .gnt_any (gntAny)
    );

    assign reqG     = EQL[g_q];
    // A request on the granted channel always beats the timeout.
    assign toutExit = (state_q == ST_ENIN_W) && !reqG && toutCond;

`ifdef B06_MULTI_TOUT_EN
    logic [TOUT_W-1:0] cnt_q;
    logic              tout_q;

    assign toutCond = (cnt_q == TOUT_LIM);
    assign TIMEOUT  = tout_q;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            tout_q <= toutExit;
            if (state_d == ST_ENIN)
                cnt_q <= '0;
            else if (state_q == ST_ENIN_W)
                cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_tout;
    assign unused_tout = ^TOUT_LIM;
    assign toutCond    = 1'b0;
    assign TIMEOUT     = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= ST_INIT;
            g_q     <= '0;
            last_q  <= IW'(N_CH - 1);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
        end
    end

    // Every return to WAIT records the served channel for the next search.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        case (state_q)
            ST_INIT: state_d = ST_WAIT;
            ST_WAIT: begin
                if (gntAny) begin
                    g_d     = gntIdx;
                    state_d = ST_ENIN;
                end
            end
            ST_ENIN: state_d = reqG ? ST_INTR : ST_ENIN_W;
            ST_ENIN_W: begin
                if (reqG) begin
                    state_d = ST_INTR;
                end else if (toutExit) begin
                    state_d = ST_WAIT;
                    last_d  = g_q;
                end
            end
            ST_INTR: state_d = CONT_EQL ? ST_INTR_1 : ST_INTR_W;
            ST_INTR_1, ST_INTR_W: begin
                if (!reqG) begin
                    state_d = ST_WAIT;
                    last_d  = g_q;
                end else begin
                    state_d = ST_INTR_W;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        USCITE       = USC_IDLE;
        ENABLE_COUNT = 1'b0;
        ACKOUT       = 1'b0;
        CC_VALID     = 1'b1;
        CC_MUX       = g_q;
        case (state_q)
            ST_ENIN, ST_ENIN_W: begin
                USCITE       = USC_EN;
                ENABLE_COUNT = 1'b1;
            end
            ST_INTR, ST_INTR_W: begin
                USCITE = USC_INT;
                ACKOUT = 1'b1;
            end
            ST_INTR_1: begin
                USCITE = USC_INT1;
                ACKOUT = 1'b1;
            end
            default: begin
                CC_VALID = 1'b0;
                CC_MUX   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_b06_multi_ctrl.sv
// Self-checking bench for b06_multi_ctrl: directed scenarios followed by
// random traffic, all compared against a phase-level reference model.
module tb_b06_multi_ctrl;

    localparam int N_CH   = 4;
    localparam int TOUT_W = 8;
    localparam int IW     = 2;
`ifdef B06_MULTI_TOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    // Phase numbering of the reference model, indexes the output tables.
    localparam int P_INIT = 0, P_WAIT = 1, P_ENIN = 2, P_ENIN_W = 3,
                   P_INTR = 4, P_INTR_1 = 5, P_INTR_W = 6;

    logic              CLOCK = 1'b0;
    logic              RESET_N;
    logic [N_CH-1:0]   EQL;
    logic              CONT_EQL;
    logic [TOUT_W-1:0] TOUT_LIM;
    logic              ACKOUT;
    logic [IW-1:0]     CC_MUX;
    logic              CC_VALID;
    logic [1:0]        USCITE;
    logic              ENABLE_COUNT;
    logic              TIMEOUT;

    int compared   = 0;
    int mismatched = 0;

    int mPh, mG, mLast, mCnt;
    bit mTout;

    int uscTab[7] = '{0, 0, 1, 1, 2, 3, 2};
    int enTab[7]  = '{0, 0, 1, 1, 0, 0, 0};
    int ackTab[7] = '{0, 0, 0, 0, 1, 1, 1};
    int valTab[7] = '{0, 0, 1, 1, 1, 1, 1};

    always #5 CLOCK = ~CLOCK;

    b06_multi_ctrl #(.N_CH(N_CH), .TOUT_W(TOUT_W)) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .EQL          (EQL),
        .CONT_EQL     (CONT_EQL),
        .TOUT_LIM     (TOUT_LIM),
        .ACKOUT       (ACKOUT),
        .CC_MUX       (CC_MUX),
        .CC_VALID     (CC_VALID),
        .USCITE       (USCITE),
        .ENABLE_COUNT (ENABLE_COUNT),
        .TIMEOUT      (TIMEOUT)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rstN, input logic [N_CH-1:0] eql,
                                 input bit cont, input int lim);
        RESET_N  = rstN;
        EQL      = eql;
        CONT_EQL = cont;
        TOUT_LIM = TOUT_W'(lim);
    endtask

    // Reference model of one rising edge using the currently driven inputs.
    task automatic modelEdge();
        bit reqG;
        if (!RESET_N) begin
            mPh = P_INIT; mLast = N_CH - 1; mG = 0; mCnt = 0; mTout = 0;
            return;
        end
        reqG  = EQL[mG];
        mTout = 0;
        case (mPh)
            P_INIT: mPh = P_WAIT;
            P_WAIT: begin
                for (int k = 1; k <= N_CH; k++) begin
                    if (mPh == P_WAIT && EQL[(mLast + k) % N_CH]) begin
                        mG   = (mLast + k) % N_CH;
                        mPh  = P_ENIN;
                        mCnt = 0;
                    end
                end
            end
            P_ENIN: mPh = reqG ? P_INTR : P_ENIN_W;
            P_ENIN_W: begin
                if (reqG) mPh = P_INTR;
                else if (TOUT_EN && mCnt == int'(TOUT_LIM)) begin
                    mPh = P_WAIT; mTout = 1; mLast = mG;
                end
                mCnt = (mCnt + 1) % (1 << TOUT_W);
            end
            P_INTR: mPh = CONT_EQL ? P_INTR_1 : P_INTR_W;
            default: begin
                if (!reqG) begin mPh = P_WAIT; mLast = mG; end
                else mPh = P_INTR_W;
            end
        endcase
    endtask

    task automatic checkAll();
        checkOutput("uscite",   USCITE,       uscTab[mPh]);
        checkOutput("encount",  ENABLE_COUNT, enTab[mPh]);
        checkOutput("ackout",   ACKOUT,       ackTab[mPh]);
        checkOutput("ccvalid",  CC_VALID,     valTab[mPh]);
        checkOutput("ccmux",    CC_MUX,       valTab[mPh] != 0 ? mG : 0);
        checkOutput("timeout",  TIMEOUT,      mTout);
    endtask

    task automatic advanceCycle();
        @(posedge CLOCK);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        mPh = P_INIT; mG = 0; mLast = N_CH - 1; mCnt = 0; mTout = 0;
        applyStimulus(0, 4'b0000, 0, 0);
        advanceCycle();
        advanceCycle();
        checkOutput("rst_usc", USCITE, 0);
        checkOutput("rst_valid", CC_VALID, 0);
        applyStimulus(1, 4'b0000, 0, 0);
        advanceCycle();
        advanceCycle();

        // Round-robin: first grant from last=3 picks ch1, then ch3.
        applyStimulus(1, 4'b1010, 0, 0);
        advanceCycle();
        checkOutput("rr_first", CC_MUX, 1);
        checkOutput("en_latency", ENABLE_COUNT, 1);
        advanceCycle();
        checkOutput("ack_latency", ACKOUT, 1);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 0);
        advanceCycle();
        checkOutput("back_wait", USCITE, 0);
        applyStimulus(1, 4'b1010, 0, 0);
        advanceCycle();
        checkOutput("rr_second", CC_MUX, 3);
        advanceCycle();
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 0);
        advanceCycle();

        // Continuation path on ch0: USCITE 1,2,3,2 then back to WAIT.
        applyStimulus(1, 4'b0001, 1, 0);
        advanceCycle();
        checkOutput("seq_en", USCITE, 1);
        advanceCycle();
        checkOutput("seq_int", USCITE, 2);
        advanceCycle();
        checkOutput("seq_int1", USCITE, 3);
        advanceCycle();
        checkOutput("seq_intw", USCITE, 2);
        applyStimulus(1, 4'b0000, 1, 0);
        advanceCycle();
        checkOutput("seq_wait", USCITE, 0);

        // Reset while in INTR_W.
        applyStimulus(1, 4'b0100, 0, 0);
        advanceCycle();
        advanceCycle();
        advanceCycle();
        checkOutput("pre_rst_ack", ACKOUT, 1);
        applyStimulus(0, 4'b0100, 0, 0);
        advanceCycle();
        checkOutput("mid_rst_ack", ACKOUT, 0);
        checkOutput("mid_rst_mux", CC_MUX, 0);
        applyStimulus(1, 4'b0000, 0, 0);
        advanceCycle();
        checkOutput("post_rst_usc", USCITE, 0);

`ifdef B06_MULTI_TOUT_EN
        // Timeout after four ENIN_W cycles with limit 3.
        applyStimulus(1, 4'b0010, 0, 3);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 3);
        for (int k = 0; k < 4; k++) begin
            advanceCycle();
            checkOutput("tout_wait_en", ENABLE_COUNT, 1);
        end
        advanceCycle();
        checkOutput("tout_pulse", TIMEOUT, 1);
        checkOutput("tout_usc", USCITE, 0);
        advanceCycle();
        checkOutput("tout_clear", TIMEOUT, 0);

        // Request arriving on the limit cycle wins over the timeout.
        applyStimulus(1, 4'b0100, 0, 2);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 2);
        advanceCycle();
        advanceCycle();
        advanceCycle();
        applyStimulus(1, 4'b0100, 0, 2);
        advanceCycle();
        checkOutput("race_ack", ACKOUT, 1);
        checkOutput("race_tout", TIMEOUT, 0);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 2);
        advanceCycle();

        // Limit zero: first ENIN_W cycle times out.
        applyStimulus(1, 4'b1000, 0, 0);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 0);
        advanceCycle();
        advanceCycle();
        checkOutput("lim0_tout", TIMEOUT, 1);
`else
        // Without the timeout feature ENIN_W waits indefinitely.
        applyStimulus(1, 4'b0010, 0, 3);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 3);
        for (int k = 0; k < 300; k++) advanceCycle();
        checkOutput("hold_usc", USCITE, 1);
        checkOutput("hold_tout", TIMEOUT, 0);
        applyStimulus(1, 4'b0010, 0, 3);
        advanceCycle();
        checkOutput("hold_ack", ACKOUT, 1);
        advanceCycle();
        applyStimulus(1, 4'b0000, 0, 3);
        advanceCycle();
`endif

        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            applyStimulus($urandom_range(0, 39) != 0,
                          N_CH'($urandom_range(0, 15)),
                          $urandom_range(0, 1) != 0,
                          $urandom_range(0, 4));
            advanceCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/b06_multi_ctrl.md
B06_MULTI_CTRL -- requirements
Module: b06_multi_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of request channels, legal range 2..16.
REQ-002 Parameter TOUT_W, default 8: width of the ENIN_W timeout counter and of TOUT_LIM.
REQ-003 CLOCK  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  synchronous, active-low reset.
REQ-005 EQL  in  N_CH  per-channel request/equal lines.
REQ-006 CONT_EQL  in  1  continuation qualifier, sampled in INTR only.
REQ-007 TOUT_LIM  in  TOUT_W  timeout limit for ENIN_W.
REQ-008 ACKOUT  out  1  acknowledge to the granted channel.
REQ-009 CC_MUX  out  $clog2(N_CH)  index of the granted channel.
REQ-010 CC_VALID  out  1  high when CC_MUX holds a live grant.
REQ-011 USCITE  out  2  phase code.
REQ-012 ENABLE_COUNT  out  1  count enable for the external comparator.
REQ-013 TIMEOUT  out  1  one-cycle pulse on an ENIN_W timeout.

Function
REQ-014 FSM states SHALL be INIT, WAIT, ENIN, ENIN_W, INTR, INTR_1 and INTR_W; g is the latched grant index.
REQ-015 INIT SHALL go to WAIT unconditionally.
REQ-016 In WAIT with any EQL bit set, the block SHALL grant the first set bit, searching round-robin from (last+1) mod N_CH; it SHALL latch g and go to ENIN; with no bit set it SHALL stay in WAIT.
REQ-017 In ENIN, EQL[g]=1 SHALL go to INTR; otherwise it SHALL go to ENIN_W.
REQ-018 In ENIN_W, EQL[g]=1 SHALL go to INTR; otherwise, if count==TOUT_LIM, it SHALL go to WAIT with TIMEOUT=1; otherwise it SHALL stay in ENIN_W.
REQ-019 EQL[g]=1 SHALL take priority over timeout when both occur in the same cycle.
REQ-020 The timeout count SHALL clear on entry to ENIN, increment once per ENIN_W cycle, and wrap modulo 2^TOUT_W.
REQ-021 With TOUT_LIM=0, the first ENIN_W cycle SHALL time out.
REQ-022 In INTR, CONT_EQL=1 SHALL go to INTR_1; otherwise it SHALL go to INTR_W.
REQ-023 In INTR_1, EQL[g]=0 SHALL go to WAIT; otherwise it SHALL go to INTR_W.
REQ-024 In INTR_W, EQL[g]=0 SHALL go to WAIT; otherwise it SHALL stay in INTR_W.
REQ-025 last SHALL update to g on every exit to WAIT, including a timeout exit.
REQ-026 Outputs SHALL be a Moore decode of registered state only, with no combinational input-to-output path.
REQ-027 USCITE SHALL be 0 in INIT and WAIT, 1 in ENIN and ENIN_W, 2 in INTR and INTR_W, and 3 in INTR_1.
REQ-028 ENABLE_COUNT SHALL be 1 in ENIN and ENIN_W only.
REQ-029 ACKOUT SHALL be 1 in INTR, INTR_1 and INTR_W only.
REQ-030 CC_VALID SHALL be 1 in every state except INIT and WAIT; CC_MUX SHALL hold g in those states and 0 otherwise.
REQ-031 TIMEOUT SHALL be registered and high for exactly the first WAIT cycle after a timeout exit.
REQ-032 Latency SHALL be: EQL set in WAIT -> ENABLE_COUNT=1 one cycle later; EQL[g] seen in ENIN -> ACKOUT=1 one cycle later.
REQ-033 Changes on non-granted EQL bits SHALL be ignored outside WAIT.

Reset
REQ-034 RESET_N=0 at a rising edge SHALL force state INIT, last=N_CH-1, g=0 and count=0, in any state.
REQ-035 During and after reset, all outputs SHALL be 0 until a grant is made.
REQ-036 Reset SHALL override every transition in the same cycle.

Configuration
REQ-037 With macro B06_MULTI_TOUT_EN defined, REQ-018 to REQ-021 and REQ-031 SHALL apply.
REQ-038 Without B06_MULTI_TOUT_EN: no counter, ENIN_W waits indefinitely for EQL[g], TIMEOUT is tied 0, and TOUT_LIM is unused.

Structure
REQ-039 Package b06_multi_pkg SHALL hold the state enum and the USCITE code constants (USC_IDLE=0, USC_EN=1, USC_INT=2, USC_INT1=3).
REQ-040 The round-robin search SHALL be a sub-module b06_rr_arb (inputs req and last; outputs gnt_idx and gnt_any).

Verification
REQ-041 Reset mid-INTR_W: RESET_N=0 for one cycle -> next cycle INIT with all outputs 0, then WAIT.
REQ-042 N_CH=4, EQL=4'b1010 in WAIT after reset: CC_MUX=1; after that handshake completes, EQL=4'b1010 again: CC_MUX=3.
REQ-043 Grant ch0, EQL[0] held, CONT_EQL=1: USCITE sequence 1,2,3,2; EQL[0] dropped in INTR_W -> WAIT next cycle.
REQ-044 TOUT_LIM=3, EQL[g] dropped after WAIT: ENIN_W lasts 4 cycles, then TIMEOUT=1 for one cycle and USCITE=0.
REQ-045 EQL[g] rises in the same cycle count==TOUT_LIM: INTR entered, TIMEOUT stays 0.
REQ-046 Build without B06_MULTI_TOUT_EN, EQL[g] low for 300 cycles in ENIN_W: state holds, TIMEOUT=0 throughout.
